rx_msg_ctrl: RTL
================

Name: rx_msg_ctrl

Overview:
Sequencer for the 32-byte receive FIFO (`fifo_rx`) on the UART receive path. It takes bytes from the UART receiver and writes them into the FIFO. It closes a message on terminator, 32 bytes or inter-byte timeout, pads unused slots, latches the flattened 256-bit FIFO contents and clears the FIFO with a read pulse. The latched message goes downstream (e.g., the SIMON cipher front end) over a valid/ready handshake.

Parameters:
- DATA_SIZE, 8, bits per byte; must match FIFO.
- ADDR_SPACE_EXP, 5, FIFO depth exponent; depth D = 2**ADDR_SPACE_EXP = 32.
- TERM_BYTE, 8'h0D, byte that closes a message; never stored.
- PAD_BYTE, 8'h00, fill byte for unused slots.
- TIMEOUT_CYCLES, 100000, idle clocks between bytes before forced close (1 ms at 100 MHz).

Ports:
- clk_100MHz  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- rx_done_tick  in  1  one-cycle strobe, rx_data valid.
- rx_data  in  DATA_SIZE  received byte.
- fifo_full  in  1  FIFO full flag.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rdata  in  DATA_SIZE*D  flattened FIFO contents; slot 0 is bits [7:0].
- fifo_write  out  1  FIFO write strobe.
- fifo_wdata  out  DATA_SIZE  FIFO write byte.
- fifo_read  out  1  FIFO read/clear strobe.
- msg_valid  out  1  message available.
- msg_ready  in  1  downstream accepts message.
- msg_data  out  DATA_SIZE*D  latched message.
- msg_len  out  ADDR_SPACE_EXP+1  count of real (non-pad) bytes, 1..32.
- overrun  out  1  sticky: a byte was dropped.
- busy  out  1  state != IDLE.

Behaviour:
- Top level ties the FIFO's active-high reset to ~reset_n.
- Reset values: all outputs 0, state IDLE, byte_cnt 0, timer 0.
- All outputs are registered.
- fifo_write and fifo_read are one-cycle pulses and are never asserted together.
- byte_cnt is 6 bits and counts FIFO writes, including pads.
- len_r holds the real-byte count; it is 0 in IDLE.
- IDLE: on rx_done_tick:
  - rx_data == TERM_BYTE: ignored (empty message), stay IDLE.
  - otherwise: next cycle fifo_write=1, fifo_wdata=rx_data, byte_cnt=len_r=1; go to COLLECT.
- COLLECT: timer increments each cycle and clears on rx_done_tick.
  - Non-terminator byte: written the next cycle; byte_cnt and len_r increment.
  - When byte_cnt reaches D: go to WAIT_FULL with no pads.
  - rx_data == TERM_BYTE: not written; go to PAD.
  - timer == TIMEOUT_CYCLES-1: go to PAD.
- PAD: one fifo_write of PAD_BYTE per cycle until byte_cnt == D, then WAIT_FULL.
  - PAD is gated on byte_cnt, not fifo_full, because fifo_full lags the write by one cycle.
- WAIT_FULL: wait for fifo_full=1 (one cycle after the D-th write). Then:
  - msg_data <= fifo_rdata, msg_len <= len_r.
  - Go to CLEAR.
- CLEAR: fifo_read=1 for one cycle; go to HANDOFF.
- HANDOFF: msg_valid=1; msg_data and msg_len stay stable while msg_valid=1.
  - On msg_valid & msg_ready: msg_valid=0 next cycle, byte_cnt=len_r=0.
  - Then require fifo_empty=1 (already true after CLEAR) and go to IDLE.
- Worst-case latency, terminator byte to msg_valid: (D - len_r) pad cycles + 3.
- rx_done_tick in PAD, WAIT_FULL, CLEAR or HANDOFF: byte dropped, overrun<=1.
  - overrun stays set until reset; it does not corrupt the held message.
- msg_ready while msg_valid=0: no effect.
- Reset mid-operation: FIFO and controller clear together; a partial message is discarded.
- Timer width is $clog2(TIMEOUT_CYCLES); the timer saturates and does not wrap.
- Byte order: first received byte lands in msg_data[7:0], byte k in msg_data[8k+7:8k].

Decomposition:
- Shared package: state encoding (IDLE, COLLECT, PAD, WAIT_FULL, CLEAR, HANDOFF), default TERM_BYTE/PAD_BYTE, the DATA_SIZE/ADDR_SPACE_EXP defaults, and msg_len width.
- One sub-module: rx_idle_timer, a clearable saturating counter with a timeout pulse.
- FIFO is instantiated in the top level, not inside this block.

Test Plan:
- Bytes 0x41, 0x42, 0x43, 0x0D -> exactly 32 FIFO writes; msg_data[23:0]=0x434241, upper bits 0; msg_len=3; one fifo_read pulse.
- 32 bytes 0x00..0x1F, no terminator -> no pad writes; msg_len=32; msg_data[255:248]=0x1F; msg_valid 3 cycles after the 32nd write.
- Bytes 0x55, 0x66, then silence for TIMEOUT_CYCLES -> pads written; msg_len=2; msg_data[15:0]=0x6655.
- msg_ready low 50 cycles during HANDOFF; send byte 0x77 -> overrun=1; msg_data unchanged; 0x77 absent from the next message.
- Lone 0x0D in IDLE -> no fifo_write, no msg_valid, busy stays 0.
- reset_n low for 2 cycles after 5 bytes, then a 2-byte message + 0x0D -> all outputs 0 during reset; next message msg_len=2 with no residue from the first 5 bytes.

Source files
------------

// File: rtl/rx_msg_ctrl_pkg.sv
// Shared state encoding, defaults and width helpers for the UART receive message sequencer.
package rx_msg_ctrl_pkg;

    localparam int unsigned DEF_DATA_SIZE      = 8;
    localparam int unsigned DEF_ADDR_SPACE_EXP = 5;
    localparam logic [7:0]  DEF_TERM_BYTE      = 8'h0D;
    localparam logic [7:0]  DEF_PAD_BYTE       = 8'h00;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 100000;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        PAD,
        WAIT_FULL,
        CLEAR,
        HANDOFF
    } rx_state_t;

    // msg_len must hold the full depth (32 needs 6 bits), hence exponent + 1.
    function automatic int unsigned msg_len_width(input int unsigned addr_exp);
        return addr_exp + 1;
    endfunction

    function automatic int unsigned timer_width(input int unsigned cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/rx_idle_timer.sv
// Clearable saturating idle counter; o_timeout is high while enabled and the count sits at TIMEOUT_CYCLES-1.
// Latency: timeout asserts TIMEOUT_CYCLES enabled cycles after the last clear.
module rx_idle_timer
    import rx_msg_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_timeout
);

    localparam int unsigned   TW   = timer_width(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != LAST)) begin
            r_cnt <= r_cnt + TW'(1);
        end
    end

    assign o_timeout = i_en && !i_clr && (r_cnt == LAST);

endmodule

// File: rtl/rx_msg_ctrl.sv
// Collects UART bytes into the rx FIFO, closes on terminator/full/timeout, pads, snapshots and clears it.
// msg_valid rises 3 cycles after the last FIFO write; while a message awaits msg_ready, new bytes are dropped and flagged.
module rx_msg_ctrl
    import rx_msg_ctrl_pkg::*;
#(
    parameter int unsigned          DATA_SIZE      = DEF_DATA_SIZE,
    parameter int unsigned          ADDR_SPACE_EXP = DEF_ADDR_SPACE_EXP,
    parameter logic [DATA_SIZE-1:0] TERM_BYTE      = DEF_TERM_BYTE,
    parameter logic [DATA_SIZE-1:0] PAD_BYTE       = DEF_PAD_BYTE,
    parameter int unsigned          TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                                     clk_100MHz,
    input  logic                                     reset_n,
    input  logic                                     rx_done_tick,
    input  logic [DATA_SIZE-1:0]                     rx_data,
    input  logic                                     fifo_full,
    input  logic                                     fifo_empty,
    input  logic [DATA_SIZE*(2**ADDR_SPACE_EXP)-1:0] fifo_rdata,
    output logic                                     fifo_write,
    output logic [DATA_SIZE-1:0]                     fifo_wdata,
    output logic                                     fifo_read,
    output logic                                     msg_valid,
    input  logic                                     msg_ready,
    output logic [DATA_SIZE*(2**ADDR_SPACE_EXP)-1:0] msg_data,
    output logic [ADDR_SPACE_EXP:0]                  msg_len,
    output logic                                     overrun,
    output logic                                     busy
);

    localparam int unsigned   DEPTH    = 2**ADDR_SPACE_EXP;
    localparam int unsigned   CW       = msg_len_width(ADDR_SPACE_EXP);
    localparam int unsigned   MW       = DATA_SIZE * DEPTH;
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    rx_state_t            r_state;
    rx_state_t            w_state_nxt;
    logic [CW-1:0]        r_byte_cnt;
    logic [CW-1:0]        w_byte_cnt_nxt;
    logic [CW-1:0]        r_len;
    logic [CW-1:0]        w_len_nxt;
    logic                 r_fifo_write;
    logic                 w_fifo_write_nxt;
    logic [DATA_SIZE-1:0] r_fifo_wdata;
    logic [DATA_SIZE-1:0] w_fifo_wdata_nxt;
    logic                 r_fifo_read;
    logic                 w_fifo_read_nxt;
    logic                 r_msg_valid;
    logic                 w_msg_valid_nxt;
    logic [MW-1:0]        r_msg_data;
    logic [CW-1:0]        r_msg_len;
    logic                 r_overrun;
    logic                 r_busy;
    logic                 w_latch;
    logic                 w_drop;
    logic                 w_timer_clr;
    logic                 w_timer_en;
    logic                 w_timeout;
    logic                 w_is_term;

    assign w_is_term = (rx_data == TERM_BYTE);

    rx_idle_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_idle_timer (
        .i_clk     (clk_100MHz),
        .i_rst_n   (reset_n),
        .i_clr     (w_timer_clr),
        .i_en      (w_timer_en),
        .o_timeout (w_timeout)
    );

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_byte_cnt_nxt   = r_byte_cnt;
        w_len_nxt        = r_len;
        w_fifo_write_nxt = 1'b0;
        w_fifo_wdata_nxt = r_fifo_wdata;
        w_fifo_read_nxt  = 1'b0;
        w_msg_valid_nxt  = r_msg_valid;
        w_latch          = 1'b0;
        w_drop           = 1'b0;
        w_timer_clr      = 1'b1;
        w_timer_en       = 1'b0;

        unique case (r_state)
            IDLE: begin
                if (rx_done_tick && !w_is_term) begin
                    w_fifo_write_nxt = 1'b1;
                    w_fifo_wdata_nxt = rx_data;
                    w_byte_cnt_nxt   = CNT_ONE;
                    w_len_nxt        = CNT_ONE;
                    w_state_nxt      = COLLECT;
                end
            end
            COLLECT: begin
                w_timer_clr = rx_done_tick;
                w_timer_en  = 1'b1;
                // A byte arriving on the timeout cycle wins: it is real data.
                if (rx_done_tick) begin
                    if (w_is_term) begin
                        w_state_nxt = PAD;
                    end else begin
                        w_fifo_write_nxt = 1'b1;
                        w_fifo_wdata_nxt = rx_data;
                        w_byte_cnt_nxt   = r_byte_cnt + CNT_ONE;
                        w_len_nxt        = r_len + CNT_ONE;
                        if (r_byte_cnt == CNT_LAST) begin
                            w_state_nxt = WAIT_FULL;
                        end
                    end
                end else if (w_timeout) begin
                    w_state_nxt = PAD;
                end
            end
            PAD: begin
                w_drop = rx_done_tick;
                // fifo_full trails the write by a cycle, so the local count decides when padding ends.
                if (r_byte_cnt == CNT_FULL) begin
                    w_state_nxt = WAIT_FULL;
                end else begin
                    w_fifo_write_nxt = 1'b1;
                    w_fifo_wdata_nxt = PAD_BYTE;
                    w_byte_cnt_nxt   = r_byte_cnt + CNT_ONE;
                    if (r_byte_cnt == CNT_LAST) begin
                        w_state_nxt = WAIT_FULL;
                    end
                end
            end
            WAIT_FULL: begin
                w_drop = rx_done_tick;
                if (fifo_full) begin
                    w_latch         = 1'b1;
                    w_fifo_read_nxt = 1'b1;
                    w_state_nxt     = CLEAR;
                end
            end
            CLEAR: begin
                w_drop          = rx_done_tick;
                w_msg_valid_nxt = 1'b1;
                w_state_nxt     = HANDOFF;
            end
            HANDOFF: begin
                w_drop = rx_done_tick;
                if (r_msg_valid && msg_ready) begin
                    w_msg_valid_nxt = 1'b0;
                    w_byte_cnt_nxt  = '0;
                    w_len_nxt       = '0;
                    if (fifo_empty) begin
                        w_state_nxt = IDLE;
                    end
                end else if (!r_msg_valid && fifo_empty) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            r_byte_cnt   <= '0;
            r_len        <= '0;
            r_fifo_write <= 1'b0;
            r_fifo_wdata <= '0;
            r_fifo_read  <= 1'b0;
            r_msg_valid  <= 1'b0;
            r_msg_data   <= '0;
            r_msg_len    <= '0;
            r_overrun    <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_byte_cnt   <= w_byte_cnt_nxt;
            r_len        <= w_len_nxt;
            r_fifo_write <= w_fifo_write_nxt;
            r_fifo_wdata <= w_fifo_wdata_nxt;
            r_fifo_read  <= w_fifo_read_nxt;
            r_msg_valid  <= w_msg_valid_nxt;
            r_overrun    <= r_overrun | w_drop;
            r_busy       <= (w_state_nxt != IDLE);
            if (w_latch) begin
                r_msg_data <= fifo_rdata;
                r_msg_len  <= r_len;
            end
        end
    end

    assign fifo_write = r_fifo_write;
    assign fifo_wdata = r_fifo_wdata;
    assign fifo_read  = r_fifo_read;
    assign msg_valid  = r_msg_valid;
    assign msg_data   = r_msg_data;
    assign msg_len    = r_msg_len;
    assign overrun    = r_overrun;
    assign busy       = r_busy;

endmodule
